// File: rtl/sp_ram_param_if.sv
// sp_ram_param_if: request/response bundle for sp_ram_param.
//   en, wr, be, addr, wdata, clr  -- requester to RAM
//   rdata, rd_valid, addr_err      -- registered read response
//   busy                           -- clear engine active, requests ignored
// master: the block issuing requests; slave: the RAM.
interface sp_ram_param_if #(
    parameter int unsigned RAM_WIDTH = 16,
    parameter int unsigned ADDR_SIZE = 3
);
    localparam int unsigned NUM_BYTES = RAM_WIDTH / 8;

    logic                 en;
    logic                 wr;
    logic [NUM_BYTES-1:0] be;
    logic [ADDR_SIZE-1:0] addr;
    logic [RAM_WIDTH-1:0] wdata;
    logic                 clr;
    logic [RAM_WIDTH-1:0] rdata;
    logic                 rd_valid;
    logic                 addr_err;
    logic                 busy;

    modport master (
        output en, wr, be, addr, wdata, clr,
        input  rdata, rd_valid, addr_err, busy
    );

    modport slave (
        input  en, wr, be, addr, wdata, clr,
        output rdata, rd_valid, addr_err, busy
    );
endinterface

// File: rtl/sp_ram_param.sv
// sp_ram_param: synchronous single-port RAM with per-byte write enables, registered read
// path with a valid strobe, selectable read-during-write readback and a clear engine that
// zeroes the array after reset or on a clr request.
//   clk_i   -- single clock, rising edge
//   rst_ni  -- synchronous active-low reset
//   bus     -- slave side of sp_ram_param_if (request, response, busy)
// READ_MODE: 0 = no readback on write, 1 = old word returned, 2 = merged new word returned.
module sp_ram_param #(
    parameter int unsigned RAM_WIDTH = 16,
    parameter int unsigned RAM_DEPTH = 8,
    parameter int unsigned ADDR_SIZE = 3,
    parameter int unsigned READ_MODE = 0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    sp_ram_param_if.slave  bus
);
    localparam int unsigned NUM_BYTES = RAM_WIDTH / 8;
    localparam logic [ADDR_SIZE-1:0] LastCnt = ADDR_SIZE'(RAM_DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   DepthW  = (ADDR_SIZE + 1)'(RAM_DEPTH);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
    logic [RAM_WIDTH-1:0] rdata_q, rdata_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 addr_err_q, addr_err_d;

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic                 in_range;
    logic                 accept;
    logic [RAM_WIDTH-1:0] old_word;
    logic [RAM_WIDTH-1:0] merged_word;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_waddr;
    logic [RAM_WIDTH-1:0] mem_wdata;

    assign in_range = ({1'b0, bus.addr} < DepthW);
    // clr wins over a same-cycle request.
    assign accept   = (state_q == StRun) && bus.en && !bus.clr;

    // Out-of-range accesses see an all-zero word, so every readback path returns 0.
    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem_q[bus.addr];
        end
        merged_word = old_word;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (bus.be[k]) begin
                merged_word[8*k +: 8] = bus.wdata[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + ADDR_SIZE'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (bus.clr) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // Output / array-write logic.
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = cnt_q;
        mem_wdata  = '0;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        if (state_q == StInit) begin
            mem_we = 1'b1;
        end else if (accept) begin
            addr_err_d = !in_range;
            if (bus.wr) begin
                if (in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.addr;
                    mem_wdata = merged_word;
                end
                if (READ_MODE == 1) begin
                    rd_valid_d = 1'b1;
                    rdata_d    = old_word;
                end else if (READ_MODE == 2) begin
                    rd_valid_d = 1'b1;
                    rdata_d    = in_range ? merged_word : '0;
                end
            end else begin
                rd_valid_d = 1'b1;
                rdata_d    = old_word;
            end
        end
    end

    // The array is left untouched while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = (state_q == StInit);
endmodule
